// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: FWFT FIFO bytes -> preamble, SFD, payload, IFG.
// Define ETH_TX_PAD_EN to zero-pad short frames up to 60 bytes.
module eth_tx_framer #(
  parameter int DATA_WIDTH   = 8,
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  r_en,
  input  logic [DATA_WIDTH:0]   r_data,
  input  logic                  r_empty,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_en,
  output logic                  tx_er,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           underrun_cnt,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_PAD  = 3'd4;
  localparam logic [2:0] S_DISC = 3'd5;
  localparam logic [2:0] S_IFG  = 3'd6;

  localparam logic [15:0] PRE_LEN  = 16'(PREAMBLE_LEN);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

  localparam logic [DATA_WIDTH-1:0] PRE_BYTE =
    DATA_WIDTH'(8'h55);
  localparam logic [DATA_WIDTH-1:0] SFD_BYTE =
    DATA_WIDTH'(8'hD5);

`ifdef ETH_TX_PAD_EN
  localparam logic [10:0] MIN_LEN = 11'd60;
`endif

  logic [2:0]            state_q, state_d;
  logic [15:0]           aux_q, aux_d;
  logic [10:0]           bcnt_q, bcnt_d;
  logic [10:0]           bcnt_inc;
  logic [15:0]           frame_q, frame_d;
  logic [15:0]           frame_inc;
  logic [15:0]           under_q, under_d;
  logic [15:0]           under_inc;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_en_q, tx_en_d;
  logic                  tx_er_q, tx_er_d;
  logic                  pop;
  logic                  last;

  assign last = r_data[DATA_WIDTH];

  assign bcnt_inc =
    (bcnt_q == 11'h7FF) ? bcnt_q : bcnt_q + 11'd1;
  assign frame_inc =
    (frame_q == 16'hFFFF) ? frame_q : frame_q + 16'd1;
  assign under_inc =
    (under_q == 16'hFFFF) ? under_q : under_q + 16'd1;

  // Each state computes the byte that goes on the line at its edge.
  always_comb begin
    state_d   = state_q;
    aux_d     = aux_q;
    bcnt_d    = bcnt_q;
    frame_d   = frame_q;
    under_d   = under_q;
    tx_data_d = '0;
    tx_en_d   = 1'b0;
    tx_er_d   = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!r_empty) begin
          tx_en_d   = 1'b1;
          tx_data_d = PRE_BYTE;
          aux_d     = 16'd1;
          bcnt_d    = '0;
          state_d   = (PRE_LEN <= 16'd1) ? S_SFD : S_PRE;
        end
      end
      S_PRE: begin
        tx_en_d   = 1'b1;
        tx_data_d = PRE_BYTE;
        aux_d     = aux_q + 16'd1;
        if ((aux_q + 16'd1) == PRE_LEN) begin
          state_d = S_SFD;
        end
      end
      S_SFD: begin
        tx_en_d   = 1'b1;
        tx_data_d = SFD_BYTE;
        state_d   = S_DATA;
      end
      S_DATA: begin
        if (!r_empty) begin
          pop       = 1'b1;
          tx_en_d   = 1'b1;
          tx_data_d = r_data[DATA_WIDTH-1:0];
          bcnt_d    = bcnt_inc;
          if (last) begin
`ifdef ETH_TX_PAD_EN
            if (bcnt_inc < MIN_LEN) begin
              state_d = S_PAD;
            end else begin
              state_d = S_IFG;
              aux_d   = '0;
              frame_d = frame_inc;
            end
`else
            state_d = S_IFG;
            aux_d   = '0;
            frame_d = frame_inc;
`endif
          end
        end else begin
          // FIFO ran dry mid-frame: poison the frame on the line.
          tx_en_d = 1'b1;
          tx_er_d = 1'b1;
          under_d = under_inc;
          state_d = S_DISC;
        end
      end
      S_PAD: begin
`ifdef ETH_TX_PAD_EN
        tx_en_d = 1'b1;
        bcnt_d  = bcnt_inc;
        if (bcnt_inc >= MIN_LEN) begin
          state_d = S_IFG;
          aux_d   = '0;
          frame_d = frame_inc;
        end
`else
        state_d = S_IFG;
        aux_d   = '0;
`endif
      end
      S_DISC: begin
        if (!r_empty) begin
          pop = 1'b1;
          if (last) begin
            state_d = S_IFG;
            aux_d   = '0;
          end
        end
      end
      S_IFG: begin
        if (aux_q == IFG_LAST) begin
          state_d = S_IDLE;
        end else begin
          aux_d = aux_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      aux_q     <= '0;
      bcnt_q    <= '0;
      frame_q   <= '0;
      under_q   <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      tx_er_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      aux_q     <= aux_d;
      bcnt_q    <= bcnt_d;
      frame_q   <= frame_d;
      under_q   <= under_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      tx_er_q   <= tx_er_d;
    end
  end

  // Reset must never consume FIFO entries.
  assign r_en         = rst_n & pop;
  assign tx_data      = tx_data_q;
  assign tx_en        = tx_en_q;
  assign tx_er        = tx_er_q;
  assign frame_cnt    = frame_q;
  assign underrun_cnt = under_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer with a FWFT FIFO model.
// Expected line streams follow ETH_TX_PAD_EN when defined.
module tb_eth_tx_framer;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          r_en;
  logic [DW:0]   r_data;
  logic          r_empty;
  logic [DW-1:0] tx_data;
  logic          tx_en;
  logic          tx_er;
  logic [15:0]   frame_cnt;
  logic [15:0]   underrun_cnt;
  logic          busy;

  eth_tx_framer #(
    .DATA_WIDTH  (DW),
    .PREAMBLE_LEN(7),
    .IFG_CYCLES  (12)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .r_en        (r_en),
    .r_data      (r_data),
    .r_empty     (r_empty),
    .tx_data     (tx_data),
    .tx_en       (tx_en),
    .tx_er       (tx_er),
    .frame_cnt   (frame_cnt),
    .underrun_cnt(underrun_cnt),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vecs;
  int          errs;
  logic [DW:0] fifo[$];
  logic [9:0]  expq[$];
  logic        pop_s;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic void fpush(input logic last,
                                input logic [7:0] d);
    fifo.push_back({last, d});
  endfunction

  function automatic void exp_add(input logic en,
                                  input logic er,
                                  input logic [7:0] d);
    expq.push_back({en, er, d});
  endfunction

  function automatic void exp_pre();
    for (int i = 0; i < 7; i++) exp_add(1'b1, 1'b0, 8'h55);
    exp_add(1'b1, 1'b0, 8'hD5);
  endfunction

  function automatic void exp_idle(input int n);
    for (int i = 0; i < n; i++) exp_add(1'b0, 1'b0, 8'h00);
  endfunction

  function automatic void exp_pad(input int nbytes);
`ifdef ETH_TX_PAD_EN
    for (int i = nbytes; i < 60; i++)
      exp_add(1'b1, 1'b0, 8'h00);
`else
    if (nbytes < 0) exp_add(1'b0, 1'b0, 8'h00);
`endif
  endfunction

  // Called at a negedge; returns at the next negedge.
  task automatic tick();
    r_empty = (fifo.size() == 0);
    r_data  = (fifo.size() != 0) ? fifo[0] : '0;
    #1;
    pop_s = r_en;
    @(posedge clk);
    if (pop_s && fifo.size() != 0) fifo.delete(0);
    @(negedge clk);
  endtask

  task automatic run_expect(input string tag);
    logic [9:0] e;
    int         n;
    n = 0;
    while (expq.size() != 0) begin
      e = expq.pop_front();
      tick();
      check($sformatf("%s[%0d]", tag, n),
            32'({tx_en, tx_er, tx_data}), 32'(e));
      n++;
    end
  endtask

  initial begin
    vecs    = 0;
    errs    = 0;
    rst_n   = 1'b0;
    r_empty = 1'b1;
    r_data  = '0;
    pop_s   = 1'b0;
    @(negedge clk);
    tick();
    tick();
    check("rst.tx_en", 32'(tx_en), 32'd0);
    check("rst.tx_er", 32'(tx_er), 32'd0);
    check("rst.tx_data", 32'(tx_data), 32'd0);
    check("rst.frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst.underrun_cnt", 32'(underrun_cnt), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle.busy", 32'(busy), 32'd0);
    check("idle.tx_en", 32'(tx_en), 32'd0);

    // Underrun after byte 5 of a 20-byte frame
    for (int i = 1; i <= 5; i++) fpush(1'b0, 8'(i));
    exp_pre();
    for (int i = 1; i <= 5; i++) exp_add(1'b1, 1'b0, 8'(i));
    exp_add(1'b1, 1'b1, 8'h00);
    run_expect("ur.head");
    check("ur.underrun_cnt", 32'(underrun_cnt), 32'd1);
    check("ur.frame_cnt", 32'(frame_cnt), 32'd0);
    check("ur.busy", 32'(busy), 32'd1);
    for (int i = 6; i <= 20; i++) fpush(i == 20, 8'(i));
    exp_idle(15 + 12);
    run_expect("ur.tail");
    check("ur.fifo_drained", 32'(fifo.size()), 32'd0);
    check("ur.busy_end", 32'(busy), 32'd0);
    check("ur.underrun_end", 32'(underrun_cnt), 32'd1);
    check("ur.frame_end", 32'(frame_cnt), 32'd0);

    // 64-byte frame 0x00..0x3F
    for (int i = 0; i < 64; i++) fpush(i == 63, 8'(i));
    exp_pre();
    for (int i = 0; i < 64; i++) exp_add(1'b1, 1'b0, 8'(i));
    exp_pad(64);
    exp_idle(12);
    run_expect("f64");
    check("f64.frame_cnt", 32'(frame_cnt), 32'd1);
    check("f64.busy", 32'(busy), 32'd0);

    // 10-byte frame (padded to 60 when enabled)
    for (int i = 0; i < 10; i++) fpush(i == 9, 8'hA0 + 8'(i));
    exp_pre();
    for (int i = 0; i < 10; i++)
      exp_add(1'b1, 1'b0, 8'hA0 + 8'(i));
    exp_pad(10);
    exp_idle(12);
    run_expect("f10");
    check("f10.frame_cnt", 32'(frame_cnt), 32'd2);

    // Two queued frames back to back
    fpush(1'b0, 8'h11);
    fpush(1'b0, 8'h22);
    fpush(1'b1, 8'h33);
    fpush(1'b0, 8'h44);
    fpush(1'b1, 8'h55);
    exp_pre();
    exp_add(1'b1, 1'b0, 8'h11);
    exp_add(1'b1, 1'b0, 8'h22);
    exp_add(1'b1, 1'b0, 8'h33);
    exp_pad(3);
    exp_idle(12);
    exp_pre();
    exp_add(1'b1, 1'b0, 8'h44);
    exp_add(1'b1, 1'b0, 8'h55);
    exp_pad(2);
    exp_idle(12);
    run_expect("b2b");
    check("b2b.frame_cnt", 32'(frame_cnt), 32'd4);
    check("b2b.underrun_cnt", 32'(underrun_cnt), 32'd1);

    // Reset during DATA, then resume with the leftover bytes
    for (int i = 0; i < 30; i++) fpush(i == 29, 8'h40 + 8'(i));
    exp_pre();
    for (int i = 0; i < 3; i++)
      exp_add(1'b1, 1'b0, 8'h40 + 8'(i));
    run_expect("mr.head");
    check("mr.busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mr.r_en0", 32'(pop_s), 32'd0);
    check("mr.tx_en", 32'(tx_en), 32'd0);
    check("mr.tx_er", 32'(tx_er), 32'd0);
    check("mr.busy", 32'(busy), 32'd0);
    check("mr.frame_cnt", 32'(frame_cnt), 32'd0);
    check("mr.underrun_cnt", 32'(underrun_cnt), 32'd0);
    tick();
    check("mr.r_en1", 32'(pop_s), 32'd0);
    check("mr.fifo_kept", 32'(fifo.size()), 32'd27);
    rst_n = 1'b1;
    exp_pre();
    for (int i = 3; i < 30; i++)
      exp_add(1'b1, 1'b0, 8'h40 + 8'(i));
    exp_pad(27);
    exp_idle(12);
    run_expect("mr.resume");
    check("mr.frame_after", 32'(frame_cnt), 32'd1);

    // frame_cnt saturation
    force dut.frame_q = 16'hFFFF;
    tick();
    release dut.frame_q;
    tick();
    check("sat.preset", 32'(frame_cnt), 32'hFFFF);
    fpush(1'b0, 8'hC1);
    fpush(1'b1, 8'hC2);
    exp_pre();
    exp_add(1'b1, 1'b0, 8'hC1);
    exp_add(1'b1, 1'b0, 8'hC2);
    exp_pad(2);
    exp_idle(12);
    run_expect("sat");
    check("sat.frame_cnt", 32'(frame_cnt), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the byte width of the transmitted data.
REQ-002 The block SHALL have parameter PREAMBLE_LEN, default 7, meaning the number of 0x55 preamble bytes before the SFD.
REQ-003 The block SHALL have parameter IFG_CYCLES, default 12, meaning the idle cycles after each frame.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port r_en, output, 1 bit: pop strobe to the FIFO read port, combinational.
REQ-007 The block SHALL have port r_data, input, DATA_WIDTH+1 bits: {last, byte}; first-word-fall-through, valid whenever r_empty=0.
REQ-008 The block SHALL have port r_empty, input, 1 bit: FIFO empty flag.
REQ-009 The block SHALL have port tx_data, output, DATA_WIDTH bits: registered line byte.
REQ-010 The block SHALL have port tx_en, output, 1 bit: registered frame-active qualifier.
REQ-011 The block SHALL have port tx_er, output, 1 bit: registered error strobe.
REQ-012 The block SHALL have port frame_cnt, output, 16 bits: count of good frames sent, saturating at 0xFFFF.
REQ-013 The block SHALL have port underrun_cnt, output, 16 bits: count of underrun-aborted frames, saturating at 0xFFFF.
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, PRE, SFD, DATA, PAD, DISCARD and IFG.
REQ-016 In IDLE, when r_empty=0, the FSM SHALL go to PRE; the first 0x55 SHALL appear on tx_data with tx_en=1 after that edge.
REQ-017 PRE SHALL drive exactly PREAMBLE_LEN cycles of 0x55 with tx_en=1; SFD SHALL then drive one cycle of 0xD5.
REQ-018 In DATA, r_en SHALL equal (r_empty=0), and no pop SHALL occur in any other state except DISCARD.
REQ-019 Each popped byte SHALL be registered onto tx_data with tx_en=1 on the same edge as the pop.
REQ-020 An 11-bit byte counter SHALL count popped DATA bytes (and PAD bytes), saturate at 2047, and clear on entry to PRE.
REQ-021 When the popped entry has last=1, the FSM SHALL go to PAD if padding applies (REQ-029), otherwise to IFG, and frame_cnt SHALL increment once at frame end.
REQ-022 Underrun: in DATA with r_empty=0 false (FIFO empty), the block SHALL drive tx_en=1, tx_er=1 and tx_data=0 for one cycle, increment underrun_cnt, leave frame_cnt unchanged and go to DISCARD.
REQ-023 DISCARD SHALL assert r_en whenever r_empty=0, keep tx_en=0, and go to IFG on the edge that pops an entry with last=1.
REQ-024 IFG SHALL hold tx_en=0, tx_er=0 and tx_data=0 for exactly IFG_CYCLES cycles, then go to IDLE; a frame MAY start from IDLE on the following edge.
REQ-025 tx_er SHALL be 0 in every cycle other than the underrun cycle.
REQ-026 Counter saturation SHALL hold the value at 0xFFFF; it SHALL NOT wrap.

Reset
REQ-027 While rst_n=0 at a rising edge, the FSM SHALL enter IDLE and tx_data, tx_en, tx_er, frame_cnt, underrun_cnt, busy and the byte counter SHALL all become 0.
REQ-028 r_en SHALL be forced to 0 while rst_n=0; a reset mid-frame SHALL truncate the frame with no tx_er and leave FIFO contents untouched.

Configuration
REQ-029 With macro ETH_TX_PAD_EN defined, a frame whose last byte leaves the byte counter below 60 SHALL continue in PAD, emitting 0x00 with tx_en=1 until the count reaches 60, then go to IFG; without it, PAD SHALL be unreachable and the last byte SHALL go directly to IFG.

Verification
REQ-030 Test 1: preload 64 bytes 0x00..0x3F with last set on 0x3F -> 7x 0x55, 0xD5, then 0x00..0x3F contiguous on tx_en, then 12 idle cycles, frame_cnt=1.
REQ-031 Test 2: with ETH_TX_PAD_EN, send a 10-byte frame -> 10 data bytes followed by 50x 0x00, tx_en high for 68 cycles in total; without the macro -> tx_en high for 18 cycles.
REQ-032 Test 3: starve the FIFO after byte 5 of a 20-byte frame -> exactly one cycle of tx_er=1 with tx_data=0, underrun_cnt=1, frame_cnt=0, remaining bytes popped through last, then IFG.
REQ-033 Test 4: queue two back-to-back frames -> exactly 12 tx_en=0 cycles between the last byte of frame 1 and the first 0x55 of frame 2.
REQ-034 Test 5: assert rst_n=0 during DATA -> next edge tx_en=0, busy=0 and both counters 0, r_en=0 throughout reset; restarting the FIFO resumes with a fresh preamble.
REQ-035 Test 6: force frame_cnt to 0xFFFF and send a frame -> frame_cnt stays 0xFFFF.
